// File: rtl/mda_dac_pkg.sv
// Shared constants, register map, state encodings and the round-robin helper
// for the mda_dac serial DAC slave.
package mda_dac_pkg;

  localparam int         FRAME_W    = 24;
  localparam logic [3:0] CMD_WR_UPD = 4'b0011;

  localparam logic [3:0] REG_CH0    = 4'd0;
  localparam logic [3:0] REG_CH1    = 4'd1;
  localparam logic [3:0] REG_CH2    = 4'd2;
  localparam logic [3:0] REG_CH3    = 4'd3;
  localparam logic [3:0] REG_CH4    = 4'd4;
  localparam logic [3:0] REG_CH5    = 4'd5;
  localparam logic [3:0] REG_CH6    = 4'd6;
  localparam logic [3:0] REG_CH7    = 4'd7;
  localparam logic [3:0] REG_STATUS = 4'd8;
  localparam logic [3:0] REG_RESEND = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} dac_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_TAIL} tx_state_e;

  // First set bit of pending at or after start, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] pending, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && pending[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mda_dac_spi_tx.sv
// SPI frame transmitter: divides slave_clk into DAC_SCK, shifts a 24-bit frame
// MSB first with SDI updated on SCK falling edges, and frames it with CS_N.
module mda_dac_spi_tx
  import mda_dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               cs_n,
  output logic               sck,
  output logic               sdi
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  tx_state_e          state_q, state_d;
  logic [15:0]        div_q, div_d;
  logic [5:0]         edge_q, edge_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic               tick;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    done    = 1'b0;
    tick    = (div_q == DIV_LAST);
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_SHIFT;
          sr_d    = frame;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          edge_d  = '0;
        end
      end
      TX_SHIFT: begin
        if (tick) begin
          div_d = '0;
          sck_d = ~sck_q;
          // Data advances only as SCK falls, so the DAC samples stable bits.
          if (sck_q) sr_d = {sr_q[FRAME_W-2:0], 1'b0};
          if (edge_q == 6'd47) state_d = TX_TAIL;
          else                 edge_d  = edge_q + 6'd1;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      TX_TAIL: begin
        if (tick) begin
          done    = 1'b1;
          cs_n_d  = 1'b1;
          div_d   = '0;
          state_d = TX_IDLE;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      sr_q    <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sr_q    <= sr_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign busy = (state_q != TX_IDLE);
  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign sdi  = sr_q[FRAME_W-1];

endmodule

// File: rtl/mda_dac.sv
// Avalon-MM slave holding eight DAC channel codes; pending channels are sent
// round-robin as 24-bit write-and-update frames through mda_dac_spi_tx.
module mda_dac
  import mda_dac_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CS_GAP  = 2
) (
  input  logic        slave_clk,
  input  logic        slave_reset_n,
  input  logic        slave_chipselect_n,
  input  logic [3:0]  slave_addr,
  input  logic        slave_read_n,
  input  logic        slave_write_n,
  input  logic [15:0] slave_writedata,
  output logic [15:0] slave_readdata,
  output logic        DAC_CS_N,
  output logic        DAC_SCK,
  output logic        DAC_SDI
);

  logic [DATA_W-1:0]  ch_q [NUM_CH];
  logic [DATA_W-1:0]  ch_d [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [2:0]         rr_q, rr_d;
  dac_state_e         state_q, state_d;
  logic [15:0]        gap_q, gap_d;
  logic [FRAME_W-1:0] frame;
  logic [2:0]         pick;
  logic               start, tx_busy, tx_done, busy, wr_en;
  logic               unused_bits;

  assign wr_en       = !slave_chipselect_n && !slave_write_n;
  assign pick        = rr_pick(pending_q, rr_q);
  assign busy        = (state_q != ST_IDLE) || tx_busy;
  assign unused_bits = ^{slave_read_n, slave_writedata[15:DATA_W]};

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    ch_d      = ch_q;
    start     = 1'b0;
    frame     = {CMD_WR_UPD, 1'b0, pick, ch_q[pick], 4'b0000};
    case (state_q)
      ST_IDLE: if (pending_q != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        start           = 1'b1;
        pending_d[pick] = 1'b0;
        rr_d            = pick + 3'd1;
        state_d         = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tx_done) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == 16'(CS_GAP - 1)) state_d = ST_IDLE;
        else                          gap_d   = gap_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Bus writes are applied after the LOAD clear so a same-cycle set wins.
    if (wr_en) begin
      if (slave_addr <= REG_CH7) begin
        ch_d[slave_addr[2:0]]      = slave_writedata[DATA_W-1:0];
        pending_d[slave_addr[2:0]] = 1'b1;
      end else if (slave_addr == REG_RESEND) begin
        pending_d = pending_d | slave_writedata[NUM_CH-1:0];
      end
    end
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_addr <= REG_CH7)          slave_readdata = 16'(ch_q[slave_addr[2:0]]);
    else if (slave_addr == REG_STATUS)  slave_readdata = {7'b0, busy, pending_q};
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      state_q   <= ST_IDLE;
      gap_q     <= '0;
    end else begin
      ch_q      <= ch_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      state_q   <= state_d;
      gap_q     <= gap_d;
    end
  end

  mda_dac_spi_tx #(.CLK_DIV(CLK_DIV)) u_spi_tx (
    .clk   (slave_clk),
    .rst_n (slave_reset_n),
    .start (start),
    .frame (frame),
    .busy  (tx_busy),
    .done  (tx_done),
    .cs_n  (DAC_CS_N),
    .sck   (DAC_SCK),
    .sdi   (DAC_SDI)
  );

endmodule

// File: tb/tb_mda_dac.sv
// Scoreboard bench for mda_dac: a channel/pending/round-robin model predicts
// frames at stimulus time; an SPI monitor decodes DAC frames and compares.
module tb_mda_dac;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic [3:0]  addr = '0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        dac_cs_n, dac_sck, dac_sdi;

  int errors = 0;
  int checks = 0;
  int frames_seen = 0;
  int frames_pushed = 0;

  logic [23:0] exp_q[$];
  logic [3:0]  batch_a[$];
  logic [15:0] batch_d[$];

  int model_code [8];
  bit model_pend [8];
  int model_rr = 0;

  mda_dac #(.CLK_DIV(CLK_DIV), .NUM_CH(8), .DATA_W(12), .CS_GAP(2)) dut (
    .slave_clk          (clk),
    .slave_reset_n      (rst_n),
    .slave_chipselect_n (cs_n),
    .slave_addr         (addr),
    .slave_read_n       (read_n),
    .slave_write_n      (write_n),
    .slave_writedata    (wdata),
    .slave_readdata     (rdata),
    .DAC_CS_N           (dac_cs_n),
    .DAC_SCK            (dac_sck),
    .DAC_SDI            (dac_sdi)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_frame(input int ch, input int code);
    return 24'h300000 + 24'(ch * 65536) + 24'(code * 16);
  endfunction

  task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; write_n = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    cs_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; read_n = 1'b0; addr = a;
    #1 d = rdata;
    cs_n = 1'b1; read_n = 1'b1;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    read_reg(a, d);
    checkOutput(name, d, exp);
  endtask

  function automatic void model_write(input logic [3:0] a, input logic [15:0] d);
    if (a < 8) begin
      model_code[a] = d & 16'h0FFF;
      model_pend[a] = 1'b1;
    end else if (a == 9) begin
      for (int i = 0; i < 8; i++) if (d[i]) model_pend[i] = 1'b1;
    end
  endfunction

  function automatic bit model_any();
    for (int i = 0; i < 8; i++) if (model_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_send_next();
    int c;
    c = -1;
    for (int i = 0; i < 8; i++) begin
      if (c < 0 && model_pend[(model_rr + i) % 8]) c = (model_rr + i) % 8;
    end
    if (c >= 0) begin
      exp_q.push_back(exp_frame(c, model_code[c]));
      frames_pushed++;
      model_pend[c] = 1'b0;
      model_rr = (c + 1) % 8;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      model_code[i] = 0;
      model_pend[i] = 1'b0;
    end
    model_rr = 0;
  endfunction

  // First write starts a frame from an idle DUT; the rest land during it.
  task automatic run_batch();
    int k;
    applyStimulus(batch_a[0], batch_d[0]);
    model_write(batch_a[0], batch_d[0]);
    model_send_next();
    k = 1;
    while (dac_cs_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("cs_latency", k, 3);
    for (int i = 1; i < batch_a.size(); i++) begin
      applyStimulus(batch_a[i], batch_d[i]);
      model_write(batch_a[i], batch_d[i]);
    end
    while (model_any()) model_send_next();
    batch_a.delete();
    batch_d.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", (n < 5000), 1);
    repeat (120) @(negedge clk);
    checkOutput("frame_count", frames_seen, frames_pushed);
  endtask

  // SPI monitor: captures SDI on SCK rising edges while CS_N is low.
  initial begin
    logic        cs_p, sck_p, sdi_p, sdi_ok;
    logic [23:0] sh;
    int          nbits, low_cyc;
    cs_p = 1'b1; sck_p = 1'b0; sdi_p = 1'b0; sdi_ok = 1'b1;
    sh = '0; nbits = 0; low_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_p = 1'b1; sck_p = 1'b0; sdi_p = 1'b0;
        nbits = 0; low_cyc = 0;
        continue;
      end
      if (!dac_cs_n) begin
        if (cs_p) begin
          nbits = 0; low_cyc = 0; sh = '0; sdi_ok = 1'b1;
        end else if (dac_sdi !== sdi_p && !(sck_p && !dac_sck)) begin
          sdi_ok = 1'b0;
        end
        low_cyc++;
        if (!sck_p && dac_sck) begin
          sh = {sh[22:0], dac_sdi};
          nbits++;
        end
      end else if (!cs_p) begin
        frames_seen++;
        checkOutput("frame_bits", nbits, 24);
        checkOutput("cs_low_cycles", low_cyc, 49 * CLK_DIV);
        checkOutput("sdi_on_sck_fall", sdi_ok, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: got 0x%0h expected none", sh);
        end else begin
          checkOutput("frame_data", sh, exp_q.pop_front());
        end
      end else begin
        checkOutput("sck_idle_low", dac_sck, 0);
      end
      cs_p = dac_cs_n; sck_p = dac_sck; sdi_p = dac_sdi;
    end
  end

  initial begin
    int nb;
    logic [3:0] a;
    logic [15:0] d;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", dac_cs_n, 1);
    checkOutput("rst_sck", dac_sck, 0);
    checkOutput("rst_sdi", dac_sdi, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) check_reg("rst_readdata", 4'(i), 16'h0000);

    // Single write, readback and status while busy
    batch_a.push_back(4'd3); batch_d.push_back(16'h0ABC);
    run_batch();
    check_reg("rd_ch3", 4'd3, 16'h0ABC);
    check_reg("status_busy", 4'd8, 16'h0100);
    wait_idle();
    check_reg("status_idle", 4'd8, 16'h0000);

    // Upper bits dropped
    batch_a.push_back(4'd0); batch_d.push_back(16'hFFFF);
    run_batch();
    wait_idle();
    check_reg("rd_ch0", 4'd0, 16'h0FFF);

    // Round-robin: ch5 in flight, then ch1 and ch7 queued -> 5, 7, 1
    batch_a = '{4'd5, 4'd1, 4'd7}; batch_d = '{16'h0555, 16'h0111, 16'h0777};
    run_batch();
    wait_idle();

    // Rewrite during own frame -> two frames, no third
    batch_a = '{4'd2, 4'd2}; batch_d = '{16'h0111, 16'h0222};
    run_batch();
    wait_idle();
    check_reg("rd_ch2", 4'd2, 16'h0222);

    // Resend ch0 and ch7 with stored codes
    batch_a.push_back(4'd9); batch_d.push_back(16'h0081);
    run_batch();
    wait_idle();

    // Ignored addresses change nothing
    applyStimulus(4'd8, 16'hFFFF);
    applyStimulus(4'd12, 16'hFFFF);
    wait_idle();
    check_reg("ignored_status", 4'd8, 16'h0000);
    check_reg("ignored_ch0", 4'd0, 16'(model_code[0]));

    // Randomized batches
    for (int b = 0; b < 15; b++) begin
      nb = $urandom_range(1, 5);
      batch_a.push_back(4'($urandom_range(0, 7)));
      batch_d.push_back(16'($urandom));
      for (int i = 1; i < nb; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    begin a = 4'd9; d = 16'($urandom_range(0, 255)); end
          2:       begin a = 4'($urandom_range(10, 15)); d = 16'($urandom); end
          3:       begin a = 4'd8; d = 16'($urandom); end
          default: begin a = 4'($urandom_range(0, 7)); d = 16'($urandom); end
        endcase
        batch_a.push_back(a);
        batch_d.push_back(d);
      end
      run_batch();
      wait_idle();
      a = 4'($urandom_range(0, 7));
      check_reg("rand_readback", a, 16'(model_code[a]));
    end

    // Reset mid-frame
    batch_a.push_back(4'd4); batch_d.push_back(16'h0C3A);
    run_batch();
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_cs_n", dac_cs_n, 1);
    checkOutput("midrst_sck", dac_sck, 0);
    checkOutput("midrst_sdi", dac_sdi, 0);
    model_reset();
    frames_pushed = frames_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reg("midrst_ch4", 4'd4, 16'h0000);
    check_reg("midrst_status", 4'd8, 16'h0000);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
